// File: rtl/xs_rr_arbiter_if.sv
// Handshake bundle for the XOR/shift arbiter: two operand requesters and one result port.
interface xs_rr_arbiter_if #(
  parameter int W = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         res_ready;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id
  );
endinterface

// File: rtl/xs_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a shared XOR/conditional-shift unit,
// with a single-entry result register and per-requester saturating completion counters.
//
// state    | meaning
// ST_EMPTY | result register free; res_valid=0
// ST_FULL  | result register holds a result awaiting res_ready
module xs_rr_arbiter #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  xs_rr_arbiter_if.slave bus,
  input  logic          shift_en,
  input  logic          cnt_clr,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic          busy
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_q, state_d;
  logic          last_grant_q;
  logic [W-1:0]  data_q;
  logic          id_q;
  logic [CW-1:0] cnt0_q, cnt1_q;

  logic          res_valid;
  logic          can_accept;
  logic          grant;
  logic          rdy0, rdy1;
  logic          accept;
  logic          drain;
  logic [W-1:0]  op_a, op_b, op_x, op_res;

  assign res_valid  = (state_q == ST_FULL);
  assign can_accept = !res_valid || bus.res_ready;
  assign drain      = res_valid && bus.res_ready;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign rdy0   = !rst && can_accept && bus.req0_valid && !grant;
  assign rdy1   = !rst && can_accept && bus.req1_valid &&  grant;
  assign accept = rdy0 || rdy1;

  assign op_a   = grant ? bus.req1_a : bus.req0_a;
  assign op_b   = grant ? bus.req1_b : bus.req0_b;
  assign op_x   = op_a ^ op_b;
  assign op_res = (shift_en && op_a[W-1]) ? {op_x[W-2:0], 1'b0} : op_x;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q       <= op_res;
        id_q         <= grant;
        last_grant_q <= grant;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (drain) begin
      if (!id_q && (cnt0_q != CNT_MAX)) cnt0_q <= cnt0_q + 1'b1;
      if ( id_q && (cnt1_q != CNT_MAX)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = data_q;
  assign bus.res_id     = id_q;

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
  assign busy = res_valid || bus.req0_valid || bus.req1_valid;

endmodule

// File: tb/tb_xs_rr_arbiter.sv
// Directed bench for xs_rr_arbiter: expected results are queued at issue time and
// popped by an independent monitor whenever a result drains.
module tb_xs_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       shift_en;
  logic       cnt_clr;
  logic [7:0] cnt0, cnt1;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];

  xs_rr_arbiter_if #(.W(8)) bus_if ();

  xs_rr_arbiter #(.W(8), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .shift_en (shift_en),
    .cnt_clr  (cnt_clr),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, wait (bounded) for its ready, then drop valid after the accept edge.
  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input bit sh, input logic [7:0] exp);
    int n;
    logic rdy;
    shift_en = sh;
    if (id) begin
      bus_if.req1_a = a; bus_if.req1_b = b; bus_if.req1_valid = 1'b1;
    end else begin
      bus_if.req0_a = a; bus_if.req0_b = b; bus_if.req0_valid = 1'b1;
    end
    exp_q.push_back({id, exp});
    n = 0;
    @(negedge clk);
    rdy = id ? bus_if.req1_ready : bus_if.req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = id ? bus_if.req1_ready : bus_if.req0_ready;
      n++;
    end
    chk("issue_ready", {31'd0, rdy}, 32'd1);
    cyc();
    if (id) bus_if.req1_valid = 1'b0;
    else    bus_if.req0_valid = 1'b0;
  endtask

  // Monitor: every drained result must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus_if.res_valid && bus_if.res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d data=0x%0h, want none", bus_if.res_id, bus_if.res_data);
      end else begin
        chk("result_id_data", {23'd0, bus_if.res_id, bus_if.res_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; shift_en = 1'b0; cnt_clr = 1'b0;
    bus_if.req0_valid = 1'b0; bus_if.req0_a = '0; bus_if.req0_b = '0;
    bus_if.req1_valid = 1'b0; bus_if.req1_a = '0; bus_if.req1_b = '0;
    bus_if.res_ready  = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_res_valid", {31'd0, bus_if.res_valid}, 32'd0);
    chk("rst_res_data",  {24'd0, bus_if.res_data},  32'd0);
    chk("rst_res_id",    {31'd0, bus_if.res_id},    32'd0);
    chk("rst_cnt0",      {24'd0, cnt0}, 32'd0);
    chk("rst_cnt1",      {24'd0, cnt1}, 32'd0);
    chk("rst_ready0",    {31'd0, bus_if.req0_ready}, 32'd0);
    chk("rst_ready1",    {31'd0, bus_if.req1_ready}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);

    // Shift path: 0x81^0x03=0x82, a[7]=1 -> 0x04
    cyc();
    bus_if.res_ready = 1'b1;
    issue(1'b0, 8'h81, 8'h03, 1'b1, 8'h04);
    @(negedge clk);
    chk("shift_res_valid", {31'd0, bus_if.res_valid}, 32'd1);
    chk("shift_res_data",  {24'd0, bus_if.res_data},  32'h04);
    chk("shift_res_id",    {31'd0, bus_if.res_id},    32'd0);
    cyc();
    @(negedge clk);
    chk("shift_cnt0", {24'd0, cnt0}, 32'd1);
    chk("shift_drained", {31'd0, bus_if.res_valid}, 32'd0);

    // No-shift paths from req1, back to back
    cyc();
    issue(1'b1, 8'h12, 8'h34, 1'b1, 8'h26);
    issue(1'b1, 8'h81, 8'h03, 1'b0, 8'h82);
    cyc();
    cyc();
    @(negedge clk);
    chk("noshift_cnt1", {24'd0, cnt1}, 32'd2);
    chk("noshift_cnt0", {24'd0, cnt0}, 32'd1);

    // Contention: grants alternate 0,1,0,1
    cyc();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt0", {24'd0, cnt0}, 32'd0);
    chk("clr_cnt1", {24'd0, cnt1}, 32'd0);
    cyc();
    shift_en = 1'b1;
    bus_if.req0_a = 8'h0F; bus_if.req0_b = 8'hF0; bus_if.req0_valid = 1'b1;
    bus_if.req1_a = 8'hC0; bus_if.req1_b = 8'h01; bus_if.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2 == 0) ? 9'h0FF : 9'h182);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_ready0", {31'd0, bus_if.req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_ready1", {31'd0, bus_if.req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("cont_busy",   {31'd0, busy}, 32'd1);
      cyc();
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("cont_cnt0", {24'd0, cnt0}, 32'd2);
    chk("cont_cnt1", {24'd0, cnt1}, 32'd2);

    // Backpressure: held result 0x03, next op waits
    cyc();
    bus_if.res_ready = 1'b0;
    issue(1'b0, 8'h01, 8'h02, 1'b0, 8'h03);
    shift_en = 1'b1;
    bus_if.req0_a = 8'h80; bus_if.req0_b = 8'h01; bus_if.req0_valid = 1'b1;
    exp_q.push_back({1'b0, 8'h02});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready0",    {31'd0, bus_if.req0_ready}, 32'd0);
      chk("bp_res_valid", {31'd0, bus_if.res_valid},  32'd1);
      chk("bp_res_data",  {24'd0, bus_if.res_data},   32'h03);
      cyc();
    end
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready0", {31'd0, bus_if.req0_ready}, 32'd1);
    cyc();
    bus_if.req0_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_valid", {31'd0, bus_if.res_valid}, 32'd1);
    chk("bp_new_data",  {24'd0, bus_if.res_data},  32'h02);

    // Saturation: 300 back-to-back req0 ops
    cyc();
    shift_en = 1'b0;
    bus_if.req0_a = 8'h00; bus_if.req0_b = 8'h00; bus_if.req0_valid = 1'b1;
    for (int i = 0; i < 300; i++) exp_q.push_back(9'h000);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("sat_ready0", {31'd0, bus_if.req0_ready}, 32'd1);
      cyc();
    end
    bus_if.req0_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("sat_cnt0", {24'd0, cnt0}, 32'd255);
    chk("sat_cnt1", {24'd0, cnt1}, 32'd2);

    // Clear in the same cycle as a drain: 0xFF^0x01=0xFE, shifted -> 0xFC
    cyc();
    issue(1'b0, 8'hFF, 8'h01, 1'b1, 8'hFC);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_drain_cnt0", {24'd0, cnt0}, 32'd0);
    chk("clr_drain_valid", {31'd0, bus_if.res_valid}, 32'd0);

    // Reset mid-operation
    cyc();
    issue(1'b1, 8'h11, 8'h22, 1'b0, 8'h33);
    cyc();
    bus_if.res_ready = 1'b0;
    issue(1'b0, 8'h55, 8'hAA, 1'b0, 8'hFF);
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, bus_if.res_valid}, 32'd1);
    chk("pre_rst_cnt1",  {24'd0, cnt1}, 32'd1);
    cyc();
    rst = 1'b1;
    bus_if.res_ready = 1'b1;
    shift_en = 1'b0;
    bus_if.req0_a = 8'h3C; bus_if.req0_b = 8'h0F; bus_if.req0_valid = 1'b1;
    bus_if.req1_a = 8'h01; bus_if.req1_b = 8'h01; bus_if.req1_valid = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("in_rst_ready0", {31'd0, bus_if.req0_ready}, 32'd0);
    chk("in_rst_ready1", {31'd0, bus_if.req1_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    exp_q.push_back({1'b0, 8'h33});
    @(negedge clk);
    chk("post_rst_valid",  {31'd0, bus_if.res_valid}, 32'd0);
    chk("post_rst_data",   {24'd0, bus_if.res_data},  32'd0);
    chk("post_rst_cnt0",   {24'd0, cnt0}, 32'd0);
    chk("post_rst_cnt1",   {24'd0, cnt1}, 32'd0);
    chk("post_rst_ready0", {31'd0, bus_if.req0_ready}, 32'd1);
    chk("post_rst_ready1", {31'd0, bus_if.req1_ready}, 32'd0);
    cyc();
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xs_rr_arbiter.md
# xs_rr_arbiter

Two-requester round-robin arbiter and sequencer for the shared XOR/conditional-shift unit: result = a ^ b, shifted left one bit (LSB filled with 0) when a[7] is 1. Each requester presents an operand pair with valid/ready. The block grants one requester per cycle, computes the result into a single-entry output register, and holds it under valid/ready backpressure. It also keeps per-requester saturating completion counters for status readout.

## Interface
- W, 8, operand/result width; the shift decision bit is a[W-1]
- CW, 8, completion counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- shift_en  in  1  1: conditional shift enabled; 0: plain XOR; sampled at accept
- req0_valid / req1_valid  in  1  requester has an operand pair
- req0_a, req0_b / req1_a, req1_b  in  W  operands; stable while valid and not ready
- req0_ready / req1_ready  out  1  operand accepted this cycle (combinational)
- res_valid  out  1  result register holds a result
- res_data  out  W  result
- res_id  out  1  requester that issued res_data
- res_ready  in  1  consumer accepts result
- cnt_clr  in  1  synchronous clear of both counters
- cnt0 / cnt1  out  CW  results delivered per requester, saturating
- busy  out  1  res_valid OR any req valid

## Operation
- can_accept = !res_valid || res_ready (result register free or draining this cycle).
- Grant selection, combinational:
  - Only reqX_valid set: grant X.
  - Both set: grant the one that is not last_grant.
  - Neither set: no grant.
- reqX_ready = can_accept && grant==X && reqX_valid; at most one ready is high per cycle.
- Accept (reqX_valid && reqX_ready):
  - x = a ^ b.
  - res_data <= (shift_en && a[W-1]) ? {x[W-2:0],1'b0} : x.
  - res_id <= X; res_valid <= 1; last_grant <= X.
- Drain (res_valid && res_ready) with no accept in the same cycle: res_valid <= 0. res_data and res_id keep their last values.
- Drain and accept in the same cycle: the new result replaces the old one and res_valid stays 1. Full throughput is one op per cycle.
- Counters: on drain, cnt[res_id] += 1, saturating at 2^CW-1.
  - cnt_clr clears both counters and takes priority over a same-cycle increment.
- No other state. The block is a two-state FSM, EMPTY/FULL, equal to res_valid, plus last_grant.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on drain with accept, or when there is no drain.

## Timing
- Reset values:
  - res_valid=0, res_data=0, res_id=0, cnt0=cnt1=0.
  - last_grant=1, so req0 wins the first contention.
  - Combinationally, ready outputs are 0 while res_valid=0 and no valid is asserted.
- rst asserted mid-operation discards any held result and resets counters on that edge. Ready outputs are forced 0 during the rst cycle.
- Latency: accept at edge N → res_valid=1 with data in cycle N+1.
- Backpressure: while res_valid && !res_ready, both ready outputs are 0. res_data and res_id are held stable.
- Requesters may not drop valid before ready; doing so is illegal and the block behavior is unchecked.
- Fairness: with both requesters continuously valid and res_ready=1, grants alternate 0,1,0,1 starting with 0 after reset.
- busy is combinational from res_valid and the valid inputs.

## Test plan
- Shift path: reset; req0 a=0x81 b=0x03, shift_en=1, res_ready=1 → req0_ready=1 in the same cycle; next cycle res_valid=1, res_data=0x04, res_id=0; cnt0=1 after drain.
- No-shift path: req1 a=0x12 b=0x34 → res_data=0x26, res_id=1. Then with shift_en=0, req1 a=0x81 b=0x03 → res_data=0x82.
- Contention: both valid for 4 cycles, res_ready=1 → res_id sequence 0,1,0,1, one result per cycle, cnt0=cnt1=2.
- Backpressure: result pending, res_ready=0 for 3 cycles, req0 valid → req0_ready=0 and res_data stable for those 3 cycles. Raise res_ready → drain and accept in the same cycle; new result appears next cycle.
- Counter saturation and clear:
  - CW=8, 300 req0 ops → cnt0=255.
  - Assert cnt_clr in a cycle with a drain → cnt0=0 next cycle.
- Reset mid-op: res_valid=1 with res_ready=0, assert rst one cycle → res_valid=0, res_data=0, counters 0. Next contention is granted to req0.
